dbus_sram_slave: RTL and testbench

- Responder end of the core data bus: accepts dbus requests (en/we/size/addr/data) from the memory-stage controller.
- Converts each request to single-port synchronous SRAM accesses: word address, byte write enables, lane-replicated write data.
- Right-aligns read data and holds the core with dbus_stall until the access completes.
- Flags misaligned accesses; sits between the datapath MM stage and on-chip data RAM.

---
 rtl/dbus_sram_slave.sv | 138 +++++++++++++
 tb/tb_dbus_sram_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_slave.sv
// Data-bus responder that maps core load/store requests onto a single-port synchronous SRAM.
// Handles byte-lane write enables, read alignment, optional wait states and misalignment errors.
module dbus_sram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dbus_en,
   input  logic                  dbus_we,
   input  logic [1:0]            dbus_size,
   input  logic [31:0]           dbus_addr,
   input  logic [31:0]           dbus_data,
   output logic [31:0]           dbus_rdata,
   output logic                  dbus_stall,
   output logic                  dbus_error,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             we_q;
   logic [1:0]       size_q;
   logic [1:0]       lane_q;

   logic             misaligned;
   logic             accept;
   logic [31:0]      shifted;
   logic [31:0]      load_val;
   logic             unused_addr_bits;

   // Upper address bits alias onto the same SRAM words by design.
   assign unused_addr_bits = ^dbus_addr[31:ADDR_WIDTH+2];

   always_comb begin
      misaligned = 1'b0;
      case (dbus_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = dbus_addr[0];
         2'b10:   misaligned = (dbus_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // SRAM is enabled combinationally in IDLE so its data arrives in the first ACCESS cycle.
   assign accept = (state == IDLE) && dbus_en && !misaligned && !rst;

   // NOTE: every signal in a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      ram_en    = accept;
      ram_we    = 4'b0000;
      ram_wdata = dbus_data;
      case (dbus_size)
         2'b00:   ram_wdata = {4{dbus_data[7:0]}};
         2'b01:   ram_wdata = {2{dbus_data[15:0]}};
         default: ram_wdata = dbus_data;
      endcase
      if (accept && dbus_we) begin
         case (dbus_size)
            2'b00:   ram_we = 4'b0001 << dbus_addr[1:0];
            2'b01:   ram_we = 4'b0011 << {dbus_addr[1], 1'b0};
            default: ram_we = 4'b1111;
         endcase
      end
   end

   assign ram_addr   = dbus_addr[ADDR_WIDTH+1:2];
   assign dbus_stall = ((state == IDLE) && dbus_en) || (state == ACCESS);
   assign dbus_error = (state == DONE) && err_q;
   assign dbus_rdata = rdata_q;

   // Right-align the addressed lane, then zero-fill above the access size.
   assign shifted = ram_rdata >> {lane_q, 3'b000};

   always_comb begin
      load_val = shifted;
      case (size_q)
         2'b00:   load_val = {24'h0, shifted[7:0]};
         2'b01:   load_val = {16'h0, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         lane_q  <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (dbus_en) begin
                  // Latch the request so a flushed dbus_en still completes consistently.
                  we_q   <= dbus_we;
                  size_q <= dbus_size;
                  lane_q <= dbus_addr[1:0];
                  if (misaligned) begin
                     err_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     cnt   <= CNT_W'(WAIT_CYCLES);
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (!we_q) rdata_q <= load_val;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_sram_slave.sv
// Randomized self-checking bench: two slaves (no wait states / three wait states) against
// a byte-level memory model of the data bus.
module tb_dbus_sram_slave;

   localparam int AW0 = 12;
   localparam int AW3 = 6;

   logic clk;

   logic        rst0, en0, we0;
   logic [1:0]  size0;
   logic [31:0] addr0, data0, rdata0, ram_wdata0, ram_rdata0;
   logic        stall0, error0, ram_en0;
   logic [3:0]  ram_we0;
   logic [AW0-1:0] ram_addr0;

   logic        rst3, en3, we3;
   logic [1:0]  size3;
   logic [31:0] addr3, data3, rdata3, ram_wdata3, ram_rdata3;
   logic        stall3, error3, ram_en3;
   logic [3:0]  ram_we3;
   logic [AW3-1:0] ram_addr3;

   logic [31:0] mem0 [0:(1<<AW0)-1];
   logic [31:0] mem3 [0:(1<<AW3)-1];

   bit [31:0] model [2][1<<AW0];
   bit [31:0] last_rd [2];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic        stall;
      logic        error;
      logic [31:0] rdata;
      logic        ram_en;
      logic [3:0]  ram_we;
      logic [31:0] ram_addr;
      logic [31:0] ram_wdata;
   } obs_t;

   dbus_sram_slave #(.ADDR_WIDTH(AW0), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst0), .dbus_en(en0), .dbus_we(we0), .dbus_size(size0),
      .dbus_addr(addr0), .dbus_data(data0), .dbus_rdata(rdata0), .dbus_stall(stall0),
      .dbus_error(error0), .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
      .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
   );

   dbus_sram_slave #(.ADDR_WIDTH(AW3), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst3), .dbus_en(en3), .dbus_we(we3), .dbus_size(size3),
      .dbus_addr(addr3), .dbus_data(data3), .dbus_rdata(rdata3), .dbus_stall(stall3),
      .dbus_error(error3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
      .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural synchronous SRAMs: read data valid the cycle after enable.
   always @(posedge clk) begin
      if (ram_en0) begin
         for (int b = 0; b < 4; b++)
            if (ram_we0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
         ram_rdata0 <= mem0[ram_addr0];
      end
   end

   always @(posedge clk) begin
      if (ram_en3) begin
         for (int b = 0; b < 4; b++)
            if (ram_we3[b]) mem3[ram_addr3][8*b +: 8] <= ram_wdata3[8*b +: 8];
         ram_rdata3 <= mem3[ram_addr3];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t get_obs(input int w);
      obs_t o;
      if (w == 0) begin
         o = '{stall0, error0, rdata0, ram_en0, ram_we0, 32'(ram_addr0), ram_wdata0};
      end else begin
         o = '{stall3, error3, rdata3, ram_en3, ram_we3, 32'(ram_addr3), ram_wdata3};
      end
      return o;
   endfunction

   task automatic drive(input int w, input bit en, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] data);
      if (w == 0) begin
         en0 = en; we0 = we; size0 = size; addr0 = addr; data0 = data;
      end else begin
         en3 = en; we3 = we; size3 = size; addr3 = addr; data3 = data;
      end
   endtask

   function automatic int aw_of(input int w);
      return (w == 0) ? AW0 : AW3;
   endfunction

   function automatic int wait_of(input int w);
      return (w == 0) ? 0 : 3;
   endfunction

   // One complete bus transaction. Entered just after a rising edge; leaves just after the
   // edge that closes DONE, with dbus_en released.
   task automatic xact(input int w, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
      int nbytes, lane, idx, stalls, rams, stray, exp_stalls;
      bit mis, done;
      logic [3:0]  exp_we;
      logic [31:0] exp_wd, val;
      obs_t o;

      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      lane   = int'(addr[1:0]);
      mis    = (size == 2'b11) || (lane % nbytes != 0);
      idx    = int'(addr >> 2) & ((1 << aw_of(w)) - 1);
      exp_stalls = mis ? 1 : 2 + wait_of(w);

      exp_we = 4'b0000;
      if (!mis && we)
         for (int k = 0; k < nbytes; k++) exp_we[lane + k] = 1'b1;
      exp_wd = '0;
      for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = data[8*(l % nbytes) +: 8];

      drive(w, 1'b1, we, size, addr, data);
      stalls = 0; rams = 0; stray = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         o = get_obs(w);
         if (c == 0) begin
            check("issue_error_low", 32'(o.error), 32'(0));
            check("issue_ram_en", 32'(o.ram_en), 32'(!mis));
            check("issue_ram_we", 32'(o.ram_we), 32'(exp_we));
            if (!mis) check("issue_ram_addr", o.ram_addr, 32'(idx));
            if (!mis && we) check("issue_ram_wdata", o.ram_wdata, exp_wd);
         end else if (o.ram_we != 4'b0000) begin
            stray++;
         end
         if (o.ram_en) rams++;
         if (o.stall) begin
            stalls++;
         end else begin
            done = 1;
            check("done_error", 32'(o.error), 32'(mis));
            if (!mis) begin
               if (we) begin
                  for (int k = 0; k < nbytes; k++)
                     model[w][idx][8*(lane+k) +: 8] = data[8*k +: 8];
               end else begin
                  val = '0;
                  for (int k = 0; k < nbytes; k++)
                     val[8*k +: 8] = model[w][idx][8*(lane+k) +: 8];
                  last_rd[w] = val;
               end
            end
            check("done_rdata", o.rdata, last_rd[w]);
         end
         @(posedge clk); #1;
      end
      if (!done) check("timeout_no_done", 32'(0), 32'(1));
      check("stall_cycles", 32'(stalls), 32'(exp_stalls));
      check("ram_en_cycles", 32'(rams), 32'(!mis));
      check("stray_ram_we", 32'(stray), 32'(0));
      drive(w, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
   endtask

   task automatic rand_ops(input int w, input int n);
      logic [1:0]  size;
      logic [31:0] addr;
      int r, nb, off, aw;
      aw = aw_of(w);
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 9));
         size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
         off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, (4 / nb) - 1)) * nb;
         addr = (($urandom() >> (aw + 2)) << (aw + 2)) | (32'($urandom_range(0, 15)) << 2)
                | 32'(off);
         xact(w, 1'($urandom_range(0, 1)), size, addr, $urandom());
      end
   endtask

   initial begin
      obs_t o;
      for (int i = 0; i < (1 << AW0); i++) mem0[i] = '0;
      for (int i = 0; i < (1 << AW3); i++) mem3[i] = '0;
      ram_rdata0 = '0;
      ram_rdata3 = '0;
      rst0 = 1'b1;
      rst3 = 1'b1;
      drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst0 = 1'b0;
      rst3 = 1'b0;

      // Idle after reset: every output quiet for several cycles.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int w = 0; w < 2; w++) begin
            o = get_obs(w);
            check("rst_rdata", o.rdata, 32'h0);
            check("rst_flags", {28'h0, o.stall, o.error, o.ram_en, 1'b0}, 32'h0);
            check("rst_ram_we", 32'(o.ram_we), 32'h0);
         end
      end
      @(posedge clk); #1;

      // Byte store/load on the top lane.
      xact(0, 1'b1, 2'b00, 32'h0000_0003, 32'h0000_00A5);
      xact(0, 1'b0, 2'b00, 32'h0000_0003, 32'h0);
      check("lb_value", rdata0, 32'h0000_00A5);

      // Halfword and word loads, then a store must leave rdata alone.
      xact(0, 1'b1, 2'b10, 32'h0000_0010, 32'h1122_3344);
      xact(0, 1'b0, 2'b01, 32'h0000_0012, 32'h0);
      check("lh_value", rdata0, 32'h0000_1122);
      xact(0, 1'b0, 2'b10, 32'h0000_0010, 32'h0);
      check("lw_value", rdata0, 32'h1122_3344);
      xact(0, 1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF);
      check("rdata_hold_sw", rdata0, 32'h1122_3344);

      // Misaligned and illegal requests.
      xact(0, 1'b0, 2'b10, 32'h0000_0006, 32'h0);
      xact(0, 1'b1, 2'b01, 32'h0000_0005, 32'h1234_5678);
      xact(0, 1'b0, 2'b11, 32'h0000_0000, 32'h0);
      check("rdata_hold_err", rdata0, 32'h1122_3344);

      // Reset during the first ACCESS cycle of a store.
      drive(0, 1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D);
      @(negedge clk);
      check("rst_sw_issue", 32'(ram_we0), 32'hF);
      @(posedge clk); #1;
      rst0 = 1'b1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      model[0][16] = 32'hCAFE_F00D;
      last_rd[0] = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_stall", 32'(stall0), 32'(0));
         check("post_rst_error", 32'(error0), 32'(0));
         check("post_rst_rdata", rdata0, 32'h0);
      end
      @(posedge clk); #1;
      xact(0, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
      check("rst_sw_readback", rdata0, 32'hCAFE_F00D);

      // Wait-state instance: back-to-back word loads, aliasing above ADDR_WIDTH.
      xact(1, 1'b1, 2'b10, 32'h0000_0008, 32'h0BAD_F00D);
      xact(1, 1'b0, 2'b10, 32'hFFFF_FF08, 32'h0);
      check("ws_lw_alias", rdata3, 32'h0BAD_F00D);
      xact(1, 1'b0, 2'b10, 32'h0000_0008, 32'h0);

      rand_ops(0, 250);
      rand_ops(1, 120);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
